// File: rtl/pa_risc_prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_risc_pkg: mnemonic selects, opcode/ext/sub constants, loader states     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pa_risc_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_ADDC  = 5'd1,  OP_ADDL  = 5'd2,  OP_SUB   = 5'd3,
        OP_SUBB  = 5'd4,  OP_OR    = 5'd5,  OP_XOR   = 5'd6,  OP_AND   = 5'd7,
        OP_LDW   = 5'd8,  OP_LDH   = 5'd9,  OP_LDB   = 5'd10, OP_STW   = 5'd11,
        OP_STH   = 5'd12, OP_STB   = 5'd13, OP_LDO   = 5'd14, OP_LDI   = 5'd15,
        OP_BL    = 5'd16, OP_COMBT = 5'd17, OP_COMBF = 5'd18, OP_ADDI  = 5'd19,
        OP_SUBI  = 5'd20, OP_EXTRU = 5'd21, OP_EXTRS = 5'd22, OP_ZDEP  = 5'd23,
        OP_NOP   = 5'd24
    } op_sel_e;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ALU   = 2'd1,
        CLS_SHIFT = 2'd2,
        CLS_IMM   = 2'd3
    } enc_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } ld_state_e;

    localparam logic [5:0] c_opc_alu   = 6'b000010;
    localparam logic [5:0] c_opc_ldw   = 6'b010010;
    localparam logic [5:0] c_opc_ldh   = 6'b010001;
    localparam logic [5:0] c_opc_ldb   = 6'b010000;
    localparam logic [5:0] c_opc_stw   = 6'b011010;
    localparam logic [5:0] c_opc_sth   = 6'b011001;
    localparam logic [5:0] c_opc_stb   = 6'b011000;
    localparam logic [5:0] c_opc_ldo   = 6'b001101;
    localparam logic [5:0] c_opc_ldi   = 6'b001000;
    localparam logic [5:0] c_opc_bl    = 6'b111010;
    localparam logic [5:0] c_opc_combt = 6'b100000;
    localparam logic [5:0] c_opc_combf = 6'b100010;
    localparam logic [5:0] c_opc_addi  = 6'b101101;
    localparam logic [5:0] c_opc_subi  = 6'b100101;
    localparam logic [5:0] c_opc_extr  = 6'b110100;
    localparam logic [5:0] c_opc_zdep  = 6'b110101;

    localparam logic [5:0] c_ext_add   = 6'b011000;
    localparam logic [5:0] c_ext_addc  = 6'b011100;
    localparam logic [5:0] c_ext_addl  = 6'b101000;
    localparam logic [5:0] c_ext_sub   = 6'b010000;
    localparam logic [5:0] c_ext_subb  = 6'b010100;
    localparam logic [5:0] c_ext_or    = 6'b001001;
    localparam logic [5:0] c_ext_xor   = 6'b001010;
    localparam logic [5:0] c_ext_and   = 6'b001000;

    localparam logic [2:0] c_sub_extru = 3'b110;
    localparam logic [2:0] c_sub_extrs = 3'b111;
    localparam logic [2:0] c_sub_zdep  = 3'b010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pa_risc_prog_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_risc_prog_loader_if: instruction stream, memory port and CPU status     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pa_risc_prog_loader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [4:0]        op_sel;
    logic [4:0]        fa;
    logic [4:0]        fb;
    logic [15:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic [ADDR_W-2:0] word_count;
    logic              err;

    modport master (
        output start, in_valid, in_last, op_sel, fa, fb, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata,
               cpu_reset, load_done, word_count, err
    );

    modport slave (
        input  start, in_valid, in_last, op_sel, fa, fb, imm,
        output in_ready, mem_we, mem_addr, mem_wdata,
               cpu_reset, load_done, word_count, err
    );
endinterface
`default_nettype wire

// File: rtl/pa_risc_prog_loader_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_risc_encoder: combinational symbolic-instruction to PA-RISC word map    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pa_risc_encoder
    import pa_risc_pkg::*;
(
    input  wire logic [4:0]  i_op_sel,
    input  wire logic [4:0]  i_fa,
    input  wire logic [4:0]  i_fb,
    input  wire logic [15:0] i_imm,
    output logic      [31:0] o_word,
    output logic             o_invalid
);

    enc_class_e w_class;
    logic [5:0] w_op6;
    logic [5:0] w_ext6;
    logic [2:0] w_sub3;

    always_comb begin
        w_class   = CLS_NONE;
        w_op6     = 6'b0;
        w_ext6    = 6'b0;
        w_sub3    = 3'b0;
        o_invalid = 1'b0;
        case (i_op_sel)
            OP_ADD:   begin w_class = CLS_ALU;   w_ext6 = c_ext_add;  end
            OP_ADDC:  begin w_class = CLS_ALU;   w_ext6 = c_ext_addc; end
            OP_ADDL:  begin w_class = CLS_ALU;   w_ext6 = c_ext_addl; end
            OP_SUB:   begin w_class = CLS_ALU;   w_ext6 = c_ext_sub;  end
            OP_SUBB:  begin w_class = CLS_ALU;   w_ext6 = c_ext_subb; end
            OP_OR:    begin w_class = CLS_ALU;   w_ext6 = c_ext_or;   end
            OP_XOR:   begin w_class = CLS_ALU;   w_ext6 = c_ext_xor;  end
            OP_AND:   begin w_class = CLS_ALU;   w_ext6 = c_ext_and;  end
            OP_LDW:   begin w_class = CLS_IMM;   w_op6 = c_opc_ldw;   end
            OP_LDH:   begin w_class = CLS_IMM;   w_op6 = c_opc_ldh;   end
            OP_LDB:   begin w_class = CLS_IMM;   w_op6 = c_opc_ldb;   end
            OP_STW:   begin w_class = CLS_IMM;   w_op6 = c_opc_stw;   end
            OP_STH:   begin w_class = CLS_IMM;   w_op6 = c_opc_sth;   end
            OP_STB:   begin w_class = CLS_IMM;   w_op6 = c_opc_stb;   end
            OP_LDO:   begin w_class = CLS_IMM;   w_op6 = c_opc_ldo;   end
            OP_LDI:   begin w_class = CLS_IMM;   w_op6 = c_opc_ldi;   end
            OP_BL:    begin w_class = CLS_IMM;   w_op6 = c_opc_bl;    end
            OP_COMBT: begin w_class = CLS_IMM;   w_op6 = c_opc_combt; end
            OP_COMBF: begin w_class = CLS_IMM;   w_op6 = c_opc_combf; end
            OP_ADDI:  begin w_class = CLS_IMM;   w_op6 = c_opc_addi;  end
            OP_SUBI:  begin w_class = CLS_IMM;   w_op6 = c_opc_subi;  end
            OP_EXTRU: begin w_class = CLS_SHIFT; w_op6 = c_opc_extr; w_sub3 = c_sub_extru; end
            OP_EXTRS: begin w_class = CLS_SHIFT; w_op6 = c_opc_extr; w_sub3 = c_sub_extrs; end
            OP_ZDEP:  begin w_class = CLS_SHIFT; w_op6 = c_opc_zdep; w_sub3 = c_sub_zdep;  end
            OP_NOP:   begin end
            default:  o_invalid = 1'b1;
        endcase
    end

    // ALU class carries its target register in imm[4:0]
    always_comb begin
        o_word = NOP_WORD;
        case (w_class)
            CLS_ALU:   o_word = {c_opc_alu, i_fb, i_fa, 4'b0000, w_ext6, 1'b0, i_imm[4:0]};
            CLS_SHIFT: o_word = {w_op6, i_fb, i_fa, i_imm[15:13], w_sub3, i_imm[9:0]};
            CLS_IMM:   o_word = {w_op6, i_fb, i_fa, i_imm};
            default:   o_word = NOP_WORD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pa_risc_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_risc_prog_loader: encodes an instruction stream into IMEM, then         |
// | releases the CPU from reset. Revision: 1.0                                 |
// +----------------------------------------------------------------------------+
module pa_risc_prog_loader
    import pa_risc_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pa_risc_prog_loader_if.slave  bus
);

    localparam logic [ADDR_W-2:0] c_capacity = {1'b1, {(ADDR_W-2){1'b0}}};

    ld_state_e         r_state;
    ld_state_e         w_next_state;
    logic [ADDR_W-2:0] r_word_count;
    logic              r_err;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_exhausted;
    logic              w_ready;
    logic              w_accept;
    logic              w_last_slot;
    logic              w_overflow;
    logic              w_start_ok;
    logic              w_cpu_reset;
    logic              w_load_done;
    logic [31:0]       w_word;
    logic              w_invalid;

    pa_risc_encoder u_encoder (
        .i_op_sel  (bus.op_sel),
        .i_fa      (bus.fa),
        .i_fb      (bus.fb),
        .i_imm     (bus.imm),
        .o_word    (w_word),
        .o_invalid (w_invalid)
    );

    assign w_exhausted = (r_word_count == c_capacity);
    assign w_ready     = (r_state == ST_LOAD) && !w_exhausted;
    assign w_accept    = bus.in_valid && w_ready;
    assign w_last_slot = (r_word_count == c_capacity - 1'b1);
    assign w_overflow  = w_accept && w_last_slot && !bus.in_last;
    assign w_start_ok  = bus.start && ((r_state == ST_IDLE) || (r_state == ST_RUN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cpu_reset  = 1'b1;
        w_load_done  = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_next_state = ST_LOAD;
            ST_LOAD:  if (w_accept && (bus.in_last || w_last_slot)) w_next_state = ST_FLUSH;
            // one settling cycle lets the final write land before release
            ST_FLUSH: w_next_state = ST_RUN;
            ST_RUN: begin
                w_cpu_reset = 1'b0;
                w_load_done = 1'b1;
                if (w_start_ok) w_next_state = ST_LOAD;
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_count <= '0;
            r_err        <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
        end else begin
            r_mem_we <= w_accept;
            if (w_start_ok) begin
                r_word_count <= '0;
                r_err        <= 1'b0;
                r_mem_addr   <= '0;
            end else if (w_accept) begin
                r_mem_addr   <= {r_word_count[ADDR_W-3:0], 2'b00};
                r_mem_wdata  <= w_word;
                r_word_count <= r_word_count + 1'b1;
                if (w_invalid || w_overflow) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.cpu_reset  = w_cpu_reset;
    assign bus.load_done  = w_load_done;
    assign bus.word_count = r_word_count;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pa_risc_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pa_risc_prog_loader: randomized load sessions against a table model     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pa_risc_prog_loader;
    import pa_risc_pkg::*;

    typedef struct {
        int          addr;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pa_risc_prog_loader_if #(.ADDR_W(9)) bus ();
    pa_risc_prog_loader_if #(.ADDR_W(4)) s_bus ();

    pa_risc_prog_loader #(.ADDR_W(9)) u_dut (.clk(clk), .reset(rst), .bus(bus));
    pa_risc_prog_loader #(.ADDR_W(4)) u_dut_small (.clk(clk), .reset(rst), .bus(s_bus));

    int n_checks = 0;
    int n_pass   = 0;

    int          t_cls [32];
    int          t_maj [32];
    int          t_min [32];
    exp_t        exp_q [$];
    logic [31:0] cap_word [128];
    int          last_addr;
    int          we_run = 0;
    int          we_max = 0;
    int          m_count;
    bit          m_err;
    bit          rnd_gaps;
    int          s_addrs [$];
    logic [31:0] s_words [$];
    logic [31:0] s_exp [$];

    logic [4:0]  p_op  [64];
    logic [4:0]  p_fa  [64];
    logic [4:0]  p_fb  [64];
    logic [15:0] p_imm [64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_op(input op_sel_e op, input int cls, input logic [5:0] maj, input logic [5:0] mn);
        t_cls[int'(op)] = cls;
        t_maj[int'(op)] = int'(maj);
        t_min[int'(op)] = int'(mn);
    endtask

    // cls: -1 invalid, 0 nop, 1 alu, 2 shift, 3 immediate form
    task automatic init_tables();
        for (int i = 0; i < 32; i++) begin
            t_cls[i] = -1; t_maj[i] = 0; t_min[i] = 0;
        end
        set_op(OP_ADD, 1, c_opc_alu, c_ext_add);   set_op(OP_ADDC, 1, c_opc_alu, c_ext_addc);
        set_op(OP_ADDL, 1, c_opc_alu, c_ext_addl); set_op(OP_SUB, 1, c_opc_alu, c_ext_sub);
        set_op(OP_SUBB, 1, c_opc_alu, c_ext_subb); set_op(OP_OR, 1, c_opc_alu, c_ext_or);
        set_op(OP_XOR, 1, c_opc_alu, c_ext_xor);   set_op(OP_AND, 1, c_opc_alu, c_ext_and);
        set_op(OP_LDW, 3, c_opc_ldw, 6'd0);   set_op(OP_LDH, 3, c_opc_ldh, 6'd0);
        set_op(OP_LDB, 3, c_opc_ldb, 6'd0);   set_op(OP_STW, 3, c_opc_stw, 6'd0);
        set_op(OP_STH, 3, c_opc_sth, 6'd0);   set_op(OP_STB, 3, c_opc_stb, 6'd0);
        set_op(OP_LDO, 3, c_opc_ldo, 6'd0);   set_op(OP_LDI, 3, c_opc_ldi, 6'd0);
        set_op(OP_BL, 3, c_opc_bl, 6'd0);     set_op(OP_COMBT, 3, c_opc_combt, 6'd0);
        set_op(OP_COMBF, 3, c_opc_combf, 6'd0); set_op(OP_ADDI, 3, c_opc_addi, 6'd0);
        set_op(OP_SUBI, 3, c_opc_subi, 6'd0);
        set_op(OP_EXTRU, 2, c_opc_extr, {3'b0, c_sub_extru});
        set_op(OP_EXTRS, 2, c_opc_extr, {3'b0, c_sub_extrs});
        set_op(OP_ZDEP, 2, c_opc_zdep, {3'b0, c_sub_zdep});
        set_op(OP_NOP, 0, 6'd0, 6'd0);
    endtask

    function automatic logic [31:0] ref_encode(input int op, input int fa, input int fb, input int imm);
        longint w;
        if (t_cls[op] <= 0) return 32'h0;
        w = longint'(t_maj[op]) * 64'd67108864 + longint'(fb) * 2097152 + longint'(fa) * 65536;
        case (t_cls[op])
            1:       w += t_min[op] * 64 + imm % 32;
            2:       w += (imm / 8192) * 8192 + t_min[op] * 1024 + imm % 1024;
            default: w += imm;
        endcase
        return w[31:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_we) begin
            we_run++;
            if (we_run > we_max) we_max = we_run;
            cap_word[bus.mem_addr[8:2]] = bus.mem_wdata;
            last_addr = int'(bus.mem_addr);
            if (exp_q.size() == 0) begin
                chk("spurious_we", bus.mem_we, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_addr, e.addr);
                chk("wr_data", bus.mem_wdata, e.word);
            end
        end else begin
            we_run = 0;
        end
        if (s_bus.mem_we) begin
            s_addrs.push_back(int'(s_bus.mem_addr));
            s_words.push_back(s_bus.mem_wdata);
        end
    end

    task automatic start_session();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
        we_max  = 0;
        chk("start_word_count", bus.word_count, 0);
        chk("start_err", bus.err, 1'b0);
        chk("start_cpu_reset", bus.cpu_reset, 1'b1);
        chk("start_ready", bus.in_ready, 1'b1);
    endtask

    task automatic send_beat(input logic [4:0] op, input logic [4:0] fa, input logic [4:0] fb,
                             input logic [15:0] imm, input logic last);
        exp_t e;
        bit   done = 1'b0;
        bus.in_valid = 1'b1;
        bus.op_sel   = op;
        bus.fa       = fa;
        bus.fb       = fb;
        bus.imm      = imm;
        bus.in_last  = last;
        for (int k = 0; k < 20 && !done; k++) begin
            if (bus.in_ready) begin
                done   = 1'b1;
                e.addr = m_count * 4;
                e.word = ref_encode(int'(op), int'(fa), int'(fb), int'(imm));
                exp_q.push_back(e);
                if (t_cls[op] < 0) m_err = 1'b1;
                m_count++;
                if (m_count == 128 && !last) m_err = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("accept_timeout", done, 1'b1);
    endtask

    task automatic run_prog(input int n);
        for (int i = 0; i < n; i++) begin
            if (rnd_gaps) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            send_beat(p_op[i], p_fa[i], p_fb[i], p_imm[i], (i == n - 1));
        end
        chk("flush_load_done", bus.load_done, 1'b0);
        chk("flush_cpu_reset", bus.cpu_reset, 1'b1);
        chk("flush_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        chk("run_load_done", bus.load_done, 1'b1);
        chk("run_cpu_reset", bus.cpu_reset, 1'b0);
        chk("run_word_count", bus.word_count, m_count);
        chk("run_err", bus.err, m_err);
        chk("run_all_written", exp_q.size(), 0);
    endtask

    task automatic set_beat(input int i, input int op, input int fa, input int fb, input int imm);
        p_op[i] = 5'(op); p_fa[i] = 5'(fa); p_fb[i] = 5'(fb); p_imm[i] = 16'(imm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          acc;
        bit          rdy;
        logic [15:0] simm;

        init_tables();
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.op_sel = '0; bus.fa = '0; bus.fb = '0; bus.imm = '0;
        s_bus.start = 1'b0; s_bus.in_valid = 1'b0; s_bus.in_last = 1'b0;
        s_bus.op_sel = '0; s_bus.fa = '0; s_bus.fb = '0; s_bus.imm = '0;
        rnd_gaps = 1'b0;
        repeat (2) @(posedge clk); #1;

        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_reset", bus.cpu_reset, 1'b1);
        chk("rst_load_done", bus.load_done, 1'b0);
        chk("rst_word_count", bus.word_count, 0);
        chk("rst_err", bus.err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        start_session();
        set_beat(0, 0, 1, 2, 3);
        run_prog(1);
        chk("add_word", cap_word[0], 32'h08410603);

        start_session();
        set_beat(0, 15, 5, 0, 16'h0010);
        set_beat(1, 21, 6, 4, 0);
        run_prog(2);
        chk("ldi_word", cap_word[0], 32'h20050010);
        chk("extru_word", cap_word[1], 32'hD0861800);
        chk("b2b_we_run", we_max, 2);

        start_session();
        set_beat(0, 27, 3, 4, 16'h1234);
        set_beat(1, 1, 7, 8, 9);
        run_prog(2);
        chk("invalid_word", cap_word[0], 32'h0);
        repeat (5) @(posedge clk); #1;
        chk("err_sticky_in_run", bus.err, 1'b1);

        start_session();
        for (int i = 0; i < 3; i++) set_beat(i, $urandom_range(0, 24), $urandom % 32, $urandom % 32, $urandom % 65536);
        run_prog(3);
        chk("three_word_count", bus.word_count, 3);

        start_session();
        for (int i = 0; i < 32; i++) set_beat(i, i, $urandom % 32, $urandom % 32, $urandom % 65536);
        run_prog(32);

        rnd_gaps = 1'b1;
        for (int s = 0; s < 8; s++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                set_beat(i, ($urandom % 8 == 0) ? $urandom_range(25, 31) : $urandom_range(0, 24),
                         $urandom % 32, $urandom % 32, $urandom % 65536);
            end
            start_session();
            run_prog(n);
        end
        rnd_gaps = 1'b0;

        start_session();
        send_beat(5'd2, 5'd3, 5'd4, 16'h00aa, 1'b0);
        send_beat(5'd8, 5'd5, 5'd6, 16'hbeef, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_mem_we", bus.mem_we, 1'b0);
        chk("midrst_cpu_reset", bus.cpu_reset, 1'b1);
        chk("midrst_ready", bus.in_ready, 1'b0);
        chk("midrst_writes_done", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        start_session();
        set_beat(0, 19, 9, 10, 16'h0042);
        run_prog(1);
        chk("resume_addr", last_addr, 0);

        s_bus.start = 1'b1;
        @(posedge clk); #1;
        s_bus.start = 1'b0;
        s_addrs.delete(); s_words.delete();
        s_bus.in_valid = 1'b1;
        s_bus.in_last  = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            simm = 16'($urandom);
            s_bus.op_sel = 5'(i + 8); s_bus.fa = 5'(i + 1); s_bus.fb = 5'(i + 2); s_bus.imm = simm;
            rdy = s_bus.in_ready;
            if (rdy) begin
                acc++;
                s_exp.push_back(ref_encode(i + 8, i + 1, i + 2, int'(simm)));
            end
            @(posedge clk); #1;
            if (rdy && acc == 4) chk("ovf_ready_drop", s_bus.in_ready, 1'b0);
        end
        s_bus.in_valid = 1'b0;
        chk("ovf_accepted", acc, 4);
        chk("ovf_err", s_bus.err, 1'b1);
        chk("ovf_load_done", s_bus.load_done, 1'b1);
        chk("ovf_cpu_reset", s_bus.cpu_reset, 1'b0);
        chk("ovf_word_count", s_bus.word_count, 4);
        chk("ovf_writes", s_addrs.size(), 4);
        for (int i = 0; i < 4 && i < s_addrs.size(); i++) begin
            chk("ovf_addr", s_addrs[i], i * 4);
            chk("ovf_word", s_words[i], s_exp[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
